// File: rtl/gfx_rom_fetch_arb.sv
// Shares one GFX ROM port between the FIX/A/B tile-fetch channels and the CPU readback path.
// Define CPU_STARVE_GUARD_EN to force a CPU grant after STARVE_MAX layer grants.
module gfx_rom_fetch_arb #(
  parameter int unsigned AW         = 21,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk_24M,
  input  logic            RES,
  input  logic            line_start,
  input  logic [2:0]      ch_req,
  input  logic [3*AW-1:0] ch_addr,
  output logic [2:0]      ch_valid,
  output logic [DW-1:0]   ch_data,
  output logic [2:0]      ch_overrun,
  input  logic            cpu_req,
  input  logic [AW-1:0]   cpu_addr,
  output logic            cpu_ack,
  output logic [DW-1:0]   cpu_data,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic            mem_rdy,
  input  logic [DW-1:0]   mem_dout
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q, state_d;
  logic [2:0]    pend_q;
  logic [AW-1:0] paddr_q [3];
  logic [1:0]    rr_q, win_ch_q, lay_sel;
  logic          win_cpu_q, kill_q;
  logic [AW-1:0] addr_q, win_addr;
  logic          lay_any, cpu_pick, grant, grant_lay, force_cpu;
  logic [2:0]    grant_vec;

  if (STARVE_MAX == 0) begin : g_starve_chk
    $error("STARVE_MAX must be nonzero");
  end

  function automatic logic [1:0] next3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Round-robin search from rr_q; the last matching assignment has highest priority.
  always_comb begin
    lay_sel = rr_q;
    if (pend_q[next3(next3(rr_q))]) lay_sel = next3(next3(rr_q));
    if (pend_q[next3(rr_q)])        lay_sel = next3(rr_q);
    if (pend_q[rr_q])               lay_sel = rr_q;
  end

  assign lay_any   = |pend_q;
  assign cpu_pick  = cpu_req && (!lay_any || force_cpu);
  assign grant     = (state_q == StIdle) && (lay_any || cpu_req);
  assign grant_lay = grant && !cpu_pick;
  assign grant_vec = grant_lay ? (3'b001 << lay_sel) : 3'b000;
  assign win_addr  = cpu_pick ? cpu_addr : paddr_q[lay_sel];

`ifdef CPU_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 2);
  logic [SW-1:0] starve_q;

  assign force_cpu = cpu_req && (starve_q == SW'(STARVE_MAX));

  always_ff @(posedge clk_24M) begin
    if (RES || !cpu_req || (grant && cpu_pick)) begin
      starve_q <= '0;
    end else if (grant_lay && (starve_q != SW'(STARVE_MAX))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign force_cpu = 1'b0;
`endif

  // mem_req rises combinationally in IDLE so an immediate ack lands on the grant edge.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          mem_req  = 1'b1;
          mem_addr = win_addr;
          state_d  = mem_ack ? StWait : StIssue;
        end
      end
      StIssue: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = StWait;
      end
      StWait: begin
        if (mem_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A capture always wins over a same-cycle grant or line_start flush.
  always_ff @(posedge clk_24M) begin
    if (RES) begin
      pend_q     <= '0;
      ch_overrun <= '0;
      for (int i = 0; i < 3; i++) paddr_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ch_req[i]) begin
          pend_q[i]  <= 1'b1;
          paddr_q[i] <= ch_addr[i*AW +: AW];
        end else if (line_start || grant_vec[i]) begin
          pend_q[i] <= 1'b0;
        end
        if (line_start) begin
          ch_overrun[i] <= 1'b0;
        end else if (ch_req[i] && pend_q[i] && !grant_vec[i]) begin
          ch_overrun[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_24M) begin
    if (RES) begin
      state_q   <= StIdle;
      rr_q      <= 2'd0;
      addr_q    <= '0;
      win_ch_q  <= 2'd0;
      win_cpu_q <= 1'b0;
      kill_q    <= 1'b0;
      ch_valid  <= '0;
      cpu_ack   <= 1'b0;
      ch_data   <= '0;
      cpu_data  <= '0;
    end else begin
      state_q  <= state_d;
      ch_valid <= '0;
      cpu_ack  <= 1'b0;
      if (grant) begin
        addr_q    <= win_addr;
        win_cpu_q <= cpu_pick;
        win_ch_q  <= lay_sel;
        kill_q    <= line_start && !cpu_pick;
        if (!cpu_pick) rr_q <= next3(lay_sel);
      end else if (line_start && (state_q != StIdle) && !win_cpu_q) begin
        kill_q <= 1'b1;
      end
      if ((state_q == StWait) && mem_rdy) begin
        if (win_cpu_q) begin
          cpu_data <= mem_dout;
          cpu_ack  <= 1'b1;
        end else if (!(kill_q || line_start)) begin
          ch_data  <= mem_dout;
          ch_valid <= 3'b001 << win_ch_q;
        end
      end
    end
  end

endmodule

// File: doc/gfx_rom_fetch_arb.md
Name: gfx_rom_fetch_arb

Overview:
- Schedules accesses to one shared GFX ROM memory port (SDRAM controller side) on behalf of the plane address generator.
- Three tile-fetch channels share the port: FIX, A, B. The CPU ROM readback path (RMRD/CRCS) is a fourth requester.
- Each channel has a 1-entry request latch. Layers are served round-robin; the CPU is served at lowest priority, with an optional starvation guard.
- Read data is returned to the requester with a 1-cycle valid pulse.

Parameters:
AW, 21, ROM word address width
DW, 32, ROM data width
STARVE_MAX, 8, layer grants allowed while the CPU is pending before the CPU is forced next (guard feature only)

Ports:
clk_24M  in  1  single clock, all logic on rising edge
RES  in  1  synchronous reset, active-high
line_start  in  1  1-cycle strobe at start of each line; flushes layer requests
ch_req  in  3  per-layer request strobe, bit0=FIX bit1=A bit2=B
ch_addr  in  3*AW  per-layer address, slice i belongs to ch_req[i]
ch_valid  out  3  1-cycle pulse: ch_data is valid for that layer
ch_data  out  DW  returned ROM data, shared by all layers
ch_overrun  out  3  sticky; a new request replaced a still-pending one
cpu_req  in  1  level; held until cpu_ack
cpu_addr  in  AW  CPU ROM address, stable while cpu_req=1
cpu_ack  out  1  1-cycle pulse, cpu_data valid
cpu_data  out  DW  returned data for the CPU
mem_req  out  1  request to memory, held until mem_ack
mem_addr  out  AW  request address, stable while mem_req=1
mem_ack  in  1  memory accepted the request
mem_rdy  in  1  1-cycle pulse, mem_dout valid
mem_dout  in  DW  memory read data

Behaviour:
- Reset: RES=1 at a clock edge clears all state. After reset: state IDLE, all pending bits 0, ch_overrun=0, ch_valid=0, cpu_ack=0, mem_req=0, mem_addr=0, ch_data=0, cpu_data=0, RR pointer=FIX, starve counter=0.
- Reset mid-transaction: the transaction is abandoned. A late mem_rdy is ignored, because IDLE ignores mem_rdy.
- Capture: on an edge where ch_req[i]=1, pend[i]<=1 and paddr[i]<=ch_addr slice i.
  - If pend[i] was already 1 and is not being granted in that cycle, the new address replaces the old one and ch_overrun[i]<=1.
  - If pend[i] is granted in the same cycle as a new capture, the capture wins: pend[i] stays 1 with the new address. No overrun.
- FSM states:
  - IDLE: if any pend or cpu_req, select a winner, set mem_req=1 and mem_addr=winner address, clear the winner's pend bit, go ISSUE.
  - ISSUE: hold mem_req and mem_addr; on mem_ack, drop mem_req and go WAIT. If mem_ack arrives in the same cycle mem_req first rises, go WAIT on that edge.
  - WAIT: on mem_rdy, register mem_dout into ch_data or cpu_data, pulse ch_valid[winner] or cpu_ack on the next cycle, and return to IDLE on the same edge.
- Minimum latency: req edge T, mem_req high during T+1, ack in T+1, rdy in T+2, valid high during T+3.
- At most one transaction is outstanding at a time.
- Arbitration:
  - Layers are granted round-robin starting at RR pointer; after each layer grant the pointer moves to (grantee+1) mod 3.
  - The CPU is granted only when no layer is pending, unless the guard forces it.
  - cpu_req must be held by the master; it is not latched.
- line_start:
  - Clears pend[2:0] and ch_overrun[2:0].
  - If a layer transaction is in ISSUE or WAIT, it completes on the memory side but its ch_valid pulse is suppressed.
  - A CPU transaction is unaffected.
  - If ch_req and line_start coincide, the capture wins (pend set, overrun stays cleared).
- Data outputs hold their last value between pulses.

Optional Feature:
CPU_STARVE_GUARD_EN
- Defined: a counter increments on each layer grant while cpu_req=1 and saturates at STARVE_MAX. When it equals STARVE_MAX, the next IDLE grant goes to the CPU regardless of pending layers. The counter clears on a CPU grant or when cpu_req=0.
- Undefined: no counter; the CPU is strictly lowest priority and can starve indefinitely.

Test Plan:
- Idle, pulse ch_req=3'b010 with A address 0x00123; memory acks at once and gives rdy next cycle -> mem_addr=0x00123 one cycle after the request, ch_valid=3'b010 three cycles after the request, ch_data=mem_dout.
- All three ch_req pulsed on one edge, memory with fixed 2-cycle rdy -> grant order FIX, A, B; three valid pulses in that order; RR pointer ends at FIX.
- A pending and stalled (mem_ack=0), then a second ch_req[1] with addr 0x00456 -> ch_overrun[1]=1; the issued address after the stall is 0x00456; one valid pulse only.
- Layer transaction in WAIT, line_start pulsed, then mem_rdy -> no ch_valid pulse, ch_overrun=0, FSM returns to IDLE.
- Guard enabled, STARVE_MAX=8, cpu_req held while layers re-request continuously -> cpu_ack occurs after exactly 8 layer grants. Guard disabled -> no cpu_ack while layers keep requesting.
- RES asserted during WAIT, then mem_rdy pulsed -> outputs at reset values, no ch_valid or cpu_ack pulse, mem_req=0.
